delta_frame_filt: RTL and testbench

//  Parametrised successor to the grayscale delta stage. Forms |curr - base| per pixel
//  and runs it through a power-of-two running-sum moving average (ring buffer, no divider).

---
 rtl/delta_frame_filt.sv | 152 +++++++++++++++
 tb/tb_delta_frame_filt.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/delta_frame_filt.sv
// Absolute frame difference followed by a power-of-two moving-average window,
// with optional threshold binarisation. Two-register pipeline, no backpressure.
module delta_frame_filt #(
   parameter int PIX_WIDTH   = 10,
   parameter int FILTER_LOG2 = 3
) (
   input  logic                 clk,
   input  logic                 aresetn,
   input  logic                 in_valid,
   input  logic                 in_sof,
   input  logic                 is_not_blank,
   input  logic [1:0]           mode,
   input  logic [PIX_WIDTH-1:0] threshold,
   input  logic [PIX_WIDTH-1:0] base_frame,
   input  logic [PIX_WIDTH-1:0] curr_frame,
   output logic                 out_valid,
   output logic                 out_sof,
   output logic [PIX_WIDTH-1:0] out_data,
   output logic                 win_full
);

   localparam int N     = 1 << FILTER_LOG2;
   localparam int SUM_W = PIX_WIDTH + FILTER_LOG2;
   localparam int CNT_W = FILTER_LOG2 + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(N);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

   function automatic logic [PIX_WIDTH-1:0] abs_diff(input logic [PIX_WIDTH-1:0] a,
                                                     input logic [PIX_WIDTH-1:0] b);
      if (a > b) begin
         return a - b;
      end else begin
         return b - a;
      end
   endfunction

   logic                   valid_s1_r;
   logic                   sof_s1_r;
   logic                   active_s1_r;
   logic [1:0]             mode_s1_r;
   logic [PIX_WIDTH-1:0]   thr_s1_r;
   logic [PIX_WIDTH-1:0]   d_s1_r;
   logic [PIX_WIDTH-1:0]   curr_s1_r;

   logic [PIX_WIDTH-1:0]   ring_r [N];
   logic [SUM_W-1:0]       sum_r;
   logic [FILTER_LOG2-1:0] wr_ptr_r;
   logic [CNT_W-1:0]       fill_r;

   logic                   sof_v_s;
   logic                   act_v_s;
   logic [SUM_W-1:0]       sum_next_s;
   logic [PIX_WIDTH-1:0]   avg_s;
   logic [PIX_WIDTH-1:0]   data_next_s;

   assign sof_v_s = valid_s1_r & sof_s1_r;
   assign act_v_s = valid_s1_r & active_s1_r;

   // Stage 1: capture difference and per-pixel controls on each valid input.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         valid_s1_r  <= 1'b0;
         sof_s1_r    <= 1'b0;
         active_s1_r <= 1'b0;
         mode_s1_r   <= 2'd0;
         thr_s1_r    <= '0;
         d_s1_r      <= '0;
         curr_s1_r   <= '0;
      end else begin
         valid_s1_r <= in_valid;
         if (in_valid) begin
            sof_s1_r    <= in_sof;
            active_s1_r <= is_not_blank;
            mode_s1_r   <= mode;
            thr_s1_r    <= threshold;
            d_s1_r      <= abs_diff(curr_frame, base_frame);
            curr_s1_r   <= curr_frame;
         end
      end
   end

   // Next running sum and the output pixel selected by the sampled mode.
   always_comb begin
      sum_next_s  = sum_r;
      data_next_s = curr_s1_r;
      if (sof_v_s) begin
         // A new frame starts from an empty window holding only this pixel.
         sum_next_s = active_s1_r ? SUM_W'(d_s1_r) : '0;
      end else if (act_v_s) begin
         sum_next_s = sum_r + SUM_W'(d_s1_r) - SUM_W'(ring_r[wr_ptr_r]);
      end else begin
         sum_next_s = sum_r;
      end
      avg_s = sum_next_s[SUM_W-1:FILTER_LOG2];
      case (mode_s1_r)
         2'd0:    data_next_s = curr_s1_r;
         2'd1:    data_next_s = active_s1_r ? d_s1_r : '0;
         2'd2:    data_next_s = active_s1_r ? avg_s : '0;
         2'd3:    data_next_s = (active_s1_r && (avg_s > thr_s1_r)) ? '1 : '0;
         default: data_next_s = curr_s1_r;
      endcase
   end

   // Stage 2 window: ring buffer, running sum, write pointer and fill count.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < N; i++) begin
            ring_r[i] <= '0;
         end
         sum_r    <= '0;
         wr_ptr_r <= '0;
         fill_r   <= '0;
      end else if (sof_v_s) begin
         for (int i = 0; i < N; i++) begin
            ring_r[i] <= '0;
         end
         if (active_s1_r) begin
            ring_r[0] <= d_s1_r;
         end
         sum_r    <= sum_next_s;
         wr_ptr_r <= active_s1_r ? FILTER_LOG2'(1) : '0;
         fill_r   <= active_s1_r ? CNT_W'(1) : '0;
      end else if (act_v_s) begin
         ring_r[wr_ptr_r] <= d_s1_r;
         sum_r            <= sum_next_s;
         wr_ptr_r         <= wr_ptr_r + FILTER_LOG2'(1);
         fill_r           <= (fill_r == FULL_CNT) ? fill_r : fill_r + CNT_W'(1);
      end
   end

   // Stage 2 output registers; out_data holds through idle cycles.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         out_valid <= 1'b0;
         out_sof   <= 1'b0;
         out_data  <= '0;
         win_full  <= 1'b0;
      end else begin
         out_valid <= valid_s1_r;
         out_sof   <= sof_v_s;
         if (valid_s1_r) begin
            out_data <= data_next_s;
         end
         if (sof_v_s) begin
            win_full <= 1'b0;
         end else if (act_v_s && (fill_r == LAST_CNT)) begin
            win_full <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_delta_frame_filt.sv
// Directed self-checking bench for delta_frame_filt with N = 4.
module tb_delta_frame_filt;

   logic       clk = 1'b0;
   logic       aresetn;
   logic       in_valid;
   logic       in_sof;
   logic       is_not_blank;
   logic [1:0] mode;
   logic [9:0] threshold;
   logic [9:0] base_frame;
   logic [9:0] curr_frame;
   logic       out_valid;
   logic       out_sof;
   logic [9:0] out_data;
   logic       win_full;

   int n_checks = 0;
   int n_fail   = 0;

   delta_frame_filt #(.PIX_WIDTH(10), .FILTER_LOG2(2)) dut (
      .clk(clk), .aresetn(aresetn), .in_valid(in_valid), .in_sof(in_sof),
      .is_not_blank(is_not_blank), .mode(mode), .threshold(threshold),
      .base_frame(base_frame), .curr_frame(curr_frame), .out_valid(out_valid),
      .out_sof(out_sof), .out_data(out_data), .win_full(win_full)
   );

   always #5 clk = ~clk;

   task automatic drive_px(input logic v, input logic s, input logic nb, input logic [1:0] m,
                           input logic [9:0] thr, input logic [9:0] b, input logic [9:0] c);
      in_valid = v; in_sof = s; is_not_blank = nb; mode = m;
      threshold = thr; base_frame = b; curr_frame = c;
   endtask

   task automatic test_reset();
      aresetn = 1'b0;
      drive_px(1'b0, 1'b0, 1'b1, 2'd0, 10'd0, 10'd0, 10'd0);
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({out_valid, out_sof, out_data, win_full} !== 13'd0) begin
         n_fail++;
         $display("FAIL reset: got v=%0b s=%0b d=%0d wf=%0b required all 0",
                  out_valid, out_sof, out_data, win_full);
      end
      @(negedge clk);
      aresetn = 1'b1;
   endtask

   task automatic test_raw_delta();
      logic [9:0] c[2] = '{10'd100, 10'd300};
      logic [9:0] b[2] = '{10'd300, 10'd100};
      for (int i = 0; i <= 3; i++) begin
         @(negedge clk);
         if (i < 2) drive_px(1'b1, 1'b0, 1'b1, 2'd1, 10'd0, b[i], c[i]);
         else drive_px(1'b0, 1'b0, 1'b1, 2'd1, 10'd0, 10'd0, 10'd0);
         @(posedge clk);
         #1;
         n_checks++;
         if (out_valid !== (i == 1 || i == 2)) begin
            n_fail++;
            $display("FAIL raw_valid[%0d]: got %0b", i, out_valid);
         end
         if (i >= 1) begin
            n_checks++;
            if (out_data !== 10'd200) begin
               n_fail++;
               $display("FAIL raw_data[%0d]: got %0d required 200", i, out_data);
            end
         end
      end
      // mode 0 passes the current pixel through
      @(negedge clk);
      drive_px(1'b1, 1'b0, 1'b1, 2'd0, 10'd0, 10'd5, 10'd777);
      @(negedge clk);
      drive_px(1'b0, 1'b0, 1'b1, 2'd0, 10'd0, 10'd0, 10'd0);
      @(posedge clk);
      #1;
      n_checks++;
      if (out_data !== 10'd777 || out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL pass_curr: got %0d v=%0b required 777 v=1", out_data, out_valid);
      end
   endtask

   task automatic test_average();
      int dl[5] = '{40, 80, 120, 160, 200};
      int ex[5] = '{10, 30, 60, 100, 140};
      for (int i = 0; i <= 5; i++) begin
         @(negedge clk);
         if (i < 5) drive_px(1'b1, i == 0, 1'b1, 2'd2, 10'd0, 10'd300, 10'(300 + dl[i]));
         else drive_px(1'b0, 1'b0, 1'b1, 2'd2, 10'd0, 10'd0, 10'd0);
         @(posedge clk);
         #1;
         if (i >= 1) begin
            n_checks++;
            if (out_data !== 10'(ex[i-1]) || win_full !== (i >= 4) || out_sof !== (i == 1)) begin
               n_fail++;
               $display("FAIL average[%0d]: got d=%0d wf=%0b sof=%0b required d=%0d wf=%0b sof=%0b",
                        i - 1, out_data, win_full, out_sof, ex[i-1], i >= 4, i == 1);
            end
         end
      end
   endtask

   task automatic test_binarise();
      int dl[5] = '{40, 80, 120, 160, 200};
      logic [9:0] thr[2] = '{10'd99, 10'd100};
      logic [9:0] ex[2][5] = '{'{10'd0, 10'd0, 10'd0, 10'd1023, 10'd1023},
                               '{10'd0, 10'd0, 10'd0, 10'd0,    10'd1023}};
      for (int t = 0; t < 2; t++) begin
         for (int i = 0; i <= 5; i++) begin
            @(negedge clk);
            if (i < 5) drive_px(1'b1, i == 0, 1'b1, 2'd3, thr[t], 10'(100 + dl[i]), 10'd100);
            else drive_px(1'b0, 1'b0, 1'b1, 2'd3, 10'd0, 10'd0, 10'd0);
            @(posedge clk);
            #1;
            if (i >= 1) begin
               n_checks++;
               if (out_data !== ex[t][i-1]) begin
                  n_fail++;
                  $display("FAIL binarise_thr%0d[%0d]: got %0d required %0d",
                           thr[t], i - 1, out_data, ex[t][i-1]);
               end
            end
         end
      end
   endtask

   task automatic test_blank();
      int  dl[6] = '{40, 500, 80, 120, 160, 200};
      bit  nb[6] = '{1, 0, 1, 1, 1, 1};
      int  ex[6] = '{10, 0, 30, 60, 100, 140};
      for (int i = 0; i <= 6; i++) begin
         @(negedge clk);
         if (i < 6) drive_px(1'b1, i == 0, nb[i], 2'd2, 10'd0, 10'd0, 10'(dl[i]));
         else drive_px(1'b0, 1'b0, 1'b1, 2'd2, 10'd0, 10'd0, 10'd0);
         @(posedge clk);
         #1;
         if (i >= 1) begin
            n_checks++;
            if (out_data !== 10'(ex[i-1]) || out_valid !== 1'b1 || win_full !== (i >= 5)) begin
               n_fail++;
               $display("FAIL blank[%0d]: got d=%0d v=%0b wf=%0b required d=%0d v=1 wf=%0b",
                        i - 1, out_data, out_valid, win_full, ex[i-1], i >= 5);
            end
         end
      end
   endtask

   task automatic test_sof_restart();
      int dl[2] = '{400, 0};
      for (int i = 0; i <= 2; i++) begin
         @(negedge clk);
         if (i < 2) drive_px(1'b1, i == 0, 1'b1, 2'd2, 10'd0, 10'd500, 10'(500 - dl[i]));
         else drive_px(1'b0, 1'b0, 1'b1, 2'd2, 10'd0, 10'd0, 10'd0);
         @(posedge clk);
         #1;
         if (i >= 1) begin
            n_checks++;
            if (out_data !== 10'd100 || win_full !== 1'b0) begin
               n_fail++;
               $display("FAIL sof_restart[%0d]: got d=%0d wf=%0b required d=100 wf=0",
                        i - 1, out_data, win_full);
            end
         end
      end
   endtask

   task automatic test_midstream_reset();
      int dl[2] = '{8, 12};
      int ex[2] = '{2, 5};
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         drive_px(1'b1, i == 0, 1'b1, 2'd2, 10'd0, 10'd0, 10'd400);
      end
      @(posedge clk);
      #2;
      aresetn = 1'b0;
      #1;
      n_checks++;
      if ({out_valid, out_sof, out_data, win_full} !== 13'd0) begin
         n_fail++;
         $display("FAIL async_reset: got v=%0b s=%0b d=%0d wf=%0b required all 0",
                  out_valid, out_sof, out_data, win_full);
      end
      @(negedge clk);
      drive_px(1'b0, 1'b0, 1'b1, 2'd2, 10'd0, 10'd0, 10'd0);
      @(negedge clk);
      aresetn = 1'b1;
      for (int i = 0; i <= 2; i++) begin
         @(negedge clk);
         if (i < 2) drive_px(1'b1, i == 0, 1'b1, 2'd2, 10'd0, 10'd0, 10'(dl[i]));
         else drive_px(1'b0, 1'b0, 1'b1, 2'd2, 10'd0, 10'd0, 10'd0);
         @(posedge clk);
         #1;
         if (i >= 1) begin
            n_checks++;
            if (out_data !== 10'(ex[i-1]) || win_full !== 1'b0) begin
               n_fail++;
               $display("FAIL after_reset[%0d]: got d=%0d wf=%0b required d=%0d wf=0",
                        i - 1, out_data, win_full, ex[i-1]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_raw_delta();
      test_average();
      test_binarise();
      test_blank();
      test_sof_restart();
      test_midstream_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
